framebuffer_region_clear: RTL and testbench

- Second-generation framebuffer clear unit, placed between the fragment pipeline and the framebuffer writer.
- When idle it forwards the fragment stream unchanged.
- When commanded, it generates a clear-fragment stream covering either the full screen or a scissor rectangle.
- Compared with the previous unit it adds per-byte write masking, a configurable pixel width, an address stride, and a correct tlast on the final clear beat.

---
 rtl/framebuffer_region_clear_pkg.sv | 50 +++++
 rtl/framebuffer_region_clear_walker.sv | 134 +++++++++++++
 rtl/framebuffer_region_clear.sv | 167 ++++++++++++++++
 tb/tb_framebuffer_region_clear.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/framebuffer_region_clear_pkg.sv
// Shared state encoding and rectangle clamping for the framebuffer region clear unit.
package framebuffer_region_clear_pkg;

    typedef enum logic {
        STATE_IDLE  = 1'b0,
        STATE_CLEAR = 1'b1
    } state_e;

    localparam int COORD_W = 32;

    typedef struct packed {
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] y1;
    } rect_t;

    function automatic logic [COORD_W-1:0] min_coord(
        input logic [COORD_W-1:0] a,
        input logic [COORD_W-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

    // Scissor edges are clipped to the screen so the walker never leaves the framebuffer.
    function automatic rect_t clamp_rect(
        input logic               scissor_en,
        input logic [COORD_W-1:0] xres,
        input logic [COORD_W-1:0] yres,
        input logic [COORD_W-1:0] start_x,
        input logic [COORD_W-1:0] start_y,
        input logic [COORD_W-1:0] end_x,
        input logic [COORD_W-1:0] end_y
    );
        rect_t r;
        if (scissor_en) begin
            r.x0 = min_coord(start_x, xres);
            r.x1 = min_coord(end_x, xres);
            r.y0 = min_coord(start_y, yres);
            r.y1 = min_coord(end_y, yres);
        end else begin
            r.x0 = '0;
            r.x1 = xres;
            r.y0 = '0;
            r.y1 = yres;
        end
        return r;
    endfunction

endpackage

// File: rtl/framebuffer_region_clear_walker.sv
// Raster walker: emits x/y/address/last for every pixel of a non-empty rectangle under valid/ready.
module framebuffer_rect_walker
    import framebuffer_region_clear_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int X_BIT_WIDTH = 11,
    parameter int Y_BIT_WIDTH = 11
) (
    input  logic                   aclk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [X_BIT_WIDTH-1:0] rect_x0,
    input  logic [X_BIT_WIDTH-1:0] rect_x1,
    input  logic [Y_BIT_WIDTH-1:0] rect_y0,
    input  logic [Y_BIT_WIDTH-1:0] rect_y1,
    input  logic [X_BIT_WIDTH-1:0] stride,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [X_BIT_WIDTH-1:0] out_xpos,
    output logic [Y_BIT_WIDTH-1:0] out_ypos,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic                   done
);

    localparam logic [X_BIT_WIDTH:0]  X_ONE    = {{X_BIT_WIDTH{1'b0}}, 1'b1};
    localparam logic [Y_BIT_WIDTH:0]  Y_ONE    = {{Y_BIT_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [X_BIT_WIDTH-1:0] x0_q, x0_d;
    logic [X_BIT_WIDTH-1:0] x1_q, x1_d;
    logic [Y_BIT_WIDTH-1:0] y1_q, y1_d;
    logic [X_BIT_WIDTH-1:0] stride_q, stride_d;
    logic [X_BIT_WIDTH-1:0] xpos_q, xpos_d;
    logic [Y_BIT_WIDTH-1:0] ypos_q, ypos_d;
    logic [ADDR_WIDTH-1:0]  row_base_q, row_base_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;

    logic                   beat;
    logic [X_BIT_WIDTH:0]   x_inc;
    logic [X_BIT_WIDTH:0]   x0_inc;
    logic [Y_BIT_WIDTH:0]   y_inc;
    logic [X_BIT_WIDTH:0]   x1_ext;
    logic [Y_BIT_WIDTH:0]   y1_ext;
    logic [ADDR_WIDTH-1:0]  start_row_base;
    logic [ADDR_WIDTH-1:0]  next_row_base;

    assign beat           = valid_q && out_ready;
    assign x_inc          = {1'b0, xpos_q} + X_ONE;
    assign x0_inc         = {1'b0, x0_q} + X_ONE;
    assign y_inc          = {1'b0, ypos_q} + Y_ONE;
    assign x1_ext         = {1'b0, x1_q};
    assign y1_ext         = {1'b0, y1_q};
    // The only multiply: the first row's base, everything afterwards is incremental.
    assign start_row_base = ADDR_WIDTH'(rect_y0) * ADDR_WIDTH'(stride);
    assign next_row_base  = row_base_q + ADDR_WIDTH'(stride_q);

    always_comb begin
        x0_d       = x0_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        stride_d   = stride_q;
        xpos_d     = xpos_q;
        ypos_d     = ypos_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        last_d     = last_q;
        if (start && !valid_q) begin
            x0_d       = rect_x0;
            x1_d       = rect_x1;
            y1_d       = rect_y1;
            stride_d   = stride;
            xpos_d     = rect_x0;
            ypos_d     = rect_y0;
            row_base_d = start_row_base;
            addr_d     = start_row_base + ADDR_WIDTH'(rect_x0);
            valid_d    = 1'b1;
            last_d     = (({1'b0, rect_x0} + X_ONE) == {1'b0, rect_x1}) &&
                         (({1'b0, rect_y0} + Y_ONE) == {1'b0, rect_y1});
        end else if (beat) begin
            if (last_q) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
            end else if (x_inc < x1_ext) begin
                xpos_d = x_inc[X_BIT_WIDTH-1:0];
                addr_d = addr_q + ADDR_ONE;
                last_d = ((x_inc + X_ONE) == x1_ext) && (y_inc == y1_ext);
            end else begin
                xpos_d     = x0_q;
                ypos_d     = y_inc[Y_BIT_WIDTH-1:0];
                row_base_d = next_row_base;
                addr_d     = next_row_base + ADDR_WIDTH'(x0_q);
                last_d     = (x0_inc == x1_ext) && ((y_inc + Y_ONE) == y1_ext);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            x0_q       <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            stride_q   <= '0;
            xpos_q     <= '0;
            ypos_q     <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            stride_q   <= stride_d;
            xpos_q     <= xpos_d;
            ypos_q     <= ypos_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_xpos  = xpos_q;
    assign out_ypos  = ypos_q;
    assign out_addr  = addr_q;
    assign done      = beat && last_q;

endmodule

// File: rtl/framebuffer_region_clear.sv
// Framebuffer clear unit: forwards fragments when idle, otherwise streams clear fragments
// over the full screen or a clamped scissor rectangle.
module framebuffer_region_clear
    import framebuffer_region_clear_pkg::*;
#(
    parameter  int ADDR_WIDTH  = 32,
    parameter  int X_BIT_WIDTH = 11,
    parameter  int Y_BIT_WIDTH = 11,
    parameter  int PIXEL_WIDTH = 16,
    localparam int STRB_WIDTH  = PIXEL_WIDTH / 8
) (
    input  logic                   aclk,
    input  logic                   resetn,

    input  logic [PIXEL_WIDTH-1:0] confClearColor,
    input  logic [STRB_WIDTH-1:0]  confClearMask,
    input  logic [X_BIT_WIDTH-1:0] confXResolution,
    input  logic [Y_BIT_WIDTH-1:0] confYResolution,
    input  logic                   confScissorEnable,
    input  logic [X_BIT_WIDTH-1:0] confScissorStartX,
    input  logic [Y_BIT_WIDTH-1:0] confScissorStartY,
    input  logic [X_BIT_WIDTH-1:0] confScissorEndX,
    input  logic [Y_BIT_WIDTH-1:0] confScissorEndY,

    input  logic                   s_frag_tvalid,
    output logic                   s_frag_tready,
    input  logic                   s_frag_tlast,
    input  logic [PIXEL_WIDTH-1:0] s_frag_tdata,
    input  logic [STRB_WIDTH-1:0]  s_frag_tstrb,
    input  logic [ADDR_WIDTH-1:0]  s_frag_taddr,
    input  logic [X_BIT_WIDTH-1:0] s_frag_txpos,
    input  logic [Y_BIT_WIDTH-1:0] s_frag_typos,

    output logic                   m_frag_tvalid,
    input  logic                   m_frag_tready,
    output logic                   m_frag_tlast,
    output logic [PIXEL_WIDTH-1:0] m_frag_tdata,
    output logic [STRB_WIDTH-1:0]  m_frag_tstrb,
    output logic [ADDR_WIDTH-1:0]  m_frag_taddr,
    output logic [X_BIT_WIDTH-1:0] m_frag_txpos,
    output logic [Y_BIT_WIDTH-1:0] m_frag_typos,

    input  logic                   apply,
    output logic                   applied
);

    state_e                 state_q;
    logic                   applied_q;
    logic [PIXEL_WIDTH-1:0] color_q, color_d;
    logic [STRB_WIDTH-1:0]  mask_q, mask_d;

    rect_t                  rect;
    logic                   rect_empty;
    logic                   accept_apply;
    logic                   start_clear;

    logic                   walk_valid;
    logic                   walk_last;
    logic [X_BIT_WIDTH-1:0] walk_xpos;
    logic [Y_BIT_WIDTH-1:0] walk_ypos;
    logic [ADDR_WIDTH-1:0]  walk_addr;
    logic                   walk_done;

    assign rect = clamp_rect(confScissorEnable,
                             COORD_W'(confXResolution),
                             COORD_W'(confYResolution),
                             COORD_W'(confScissorStartX),
                             COORD_W'(confScissorStartY),
                             COORD_W'(confScissorEndX),
                             COORD_W'(confScissorEndY));

    assign rect_empty   = (rect.x0 >= rect.x1) || (rect.y0 >= rect.y1);
    assign accept_apply = apply && (state_q == STATE_IDLE);
    assign start_clear  = accept_apply && !rect_empty;

    always_comb begin
        color_d = color_q;
        mask_d  = mask_q;
        if (accept_apply) begin
            color_d = confClearColor;
            mask_d  = confClearMask;
        end
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            color_q <= '0;
            mask_q  <= '0;
        end else begin
            color_q <= color_d;
            mask_q  <= mask_d;
        end
    end

    framebuffer_rect_walker #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .X_BIT_WIDTH (X_BIT_WIDTH),
        .Y_BIT_WIDTH (Y_BIT_WIDTH)
    ) u_walker (
        .aclk      (aclk),
        .resetn    (resetn),
        .start     (start_clear),
        .rect_x0   (X_BIT_WIDTH'(rect.x0)),
        .rect_x1   (X_BIT_WIDTH'(rect.x1)),
        .rect_y0   (Y_BIT_WIDTH'(rect.y0)),
        .rect_y1   (Y_BIT_WIDTH'(rect.y1)),
        .stride    (confXResolution),
        .out_valid (walk_valid),
        .out_ready (m_frag_tready),
        .out_last  (walk_last),
        .out_xpos  (walk_xpos),
        .out_ypos  (walk_ypos),
        .out_addr  (walk_addr),
        .done      (walk_done)
    );

    // applied drops together with the first clear beat and returns with the cycle after the last one.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_q   <= STATE_IDLE;
            applied_q <= 1'b1;
        end else begin
            case (state_q)
                STATE_IDLE: begin
                    if (start_clear) begin
                        state_q   <= STATE_CLEAR;
                        applied_q <= 1'b0;
                    end
                end
                STATE_CLEAR: begin
                    if (walk_done) begin
                        state_q   <= STATE_IDLE;
                        applied_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= STATE_IDLE;
                    applied_q <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        s_frag_tready = m_frag_tready;
        m_frag_tvalid = s_frag_tvalid;
        m_frag_tlast  = s_frag_tlast;
        m_frag_tdata  = s_frag_tdata;
        m_frag_tstrb  = s_frag_tstrb;
        m_frag_taddr  = s_frag_taddr;
        m_frag_txpos  = s_frag_txpos;
        m_frag_typos  = s_frag_typos;
        if (state_q == STATE_CLEAR) begin
            s_frag_tready = 1'b0;
            m_frag_tvalid = walk_valid;
            m_frag_tlast  = walk_last;
            m_frag_tdata  = color_q;
            m_frag_tstrb  = mask_q;
            m_frag_taddr  = walk_addr;
            m_frag_txpos  = walk_xpos;
            m_frag_typos  = walk_ypos;
        end
    end

    assign applied = applied_q;

endmodule

// File: tb/tb_framebuffer_region_clear.sv
// Randomized bench for framebuffer_region_clear, checked against a raster-order model of the clear.
module tb_framebuffer_region_clear;

    localparam int AW = 32;
    localparam int XW = 11;
    localparam int YW = 11;
    localparam int PW = 16;
    localparam int SW = PW / 8;

    typedef struct packed {
        logic [PW-1:0] data;
        logic [SW-1:0] strb;
        logic [AW-1:0] addr;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          last;
    } beat_t;

    typedef struct {
        int            xres;
        int            yres;
        bit            sen;
        int            sx;
        int            sy;
        int            ex;
        int            ey;
        logic [PW-1:0] color;
        logic [SW-1:0] mask;
    } cfg_t;

    logic          aclk;
    logic          resetn;
    logic [PW-1:0] confClearColor;
    logic [SW-1:0] confClearMask;
    logic [XW-1:0] confXResolution;
    logic [YW-1:0] confYResolution;
    logic          confScissorEnable;
    logic [XW-1:0] confScissorStartX;
    logic [YW-1:0] confScissorStartY;
    logic [XW-1:0] confScissorEndX;
    logic [YW-1:0] confScissorEndY;
    logic          s_frag_tvalid, s_frag_tready, s_frag_tlast;
    logic [PW-1:0] s_frag_tdata;
    logic [SW-1:0] s_frag_tstrb;
    logic [AW-1:0] s_frag_taddr;
    logic [XW-1:0] s_frag_txpos;
    logic [YW-1:0] s_frag_typos;
    logic          m_frag_tvalid, m_frag_tready, m_frag_tlast;
    logic [PW-1:0] m_frag_tdata;
    logic [SW-1:0] m_frag_tstrb;
    logic [AW-1:0] m_frag_taddr;
    logic [XW-1:0] m_frag_txpos;
    logic [YW-1:0] m_frag_typos;
    logic          apply;
    logic          applied;

    int total = 0;
    int bad   = 0;

    beat_t exp_q[$];
    beat_t obs_q[$];
    bit    obs_first_valid;
    bit    obs_pass_ok;
    bit    obs_applied_stayed;
    bit    obs_timeout;
    int    obs_ctrl_errs;
    int    obs_stall_changes;

    framebuffer_region_clear #(
        .ADDR_WIDTH  (AW),
        .X_BIT_WIDTH (XW),
        .Y_BIT_WIDTH (YW),
        .PIXEL_WIDTH (PW)
    ) dut (
        .aclk              (aclk),
        .resetn            (resetn),
        .confClearColor    (confClearColor),
        .confClearMask     (confClearMask),
        .confXResolution   (confXResolution),
        .confYResolution   (confYResolution),
        .confScissorEnable (confScissorEnable),
        .confScissorStartX (confScissorStartX),
        .confScissorStartY (confScissorStartY),
        .confScissorEndX   (confScissorEndX),
        .confScissorEndY   (confScissorEndY),
        .s_frag_tvalid     (s_frag_tvalid),
        .s_frag_tready     (s_frag_tready),
        .s_frag_tlast      (s_frag_tlast),
        .s_frag_tdata      (s_frag_tdata),
        .s_frag_tstrb      (s_frag_tstrb),
        .s_frag_taddr      (s_frag_taddr),
        .s_frag_txpos      (s_frag_txpos),
        .s_frag_typos      (s_frag_typos),
        .m_frag_tvalid     (m_frag_tvalid),
        .m_frag_tready     (m_frag_tready),
        .m_frag_tlast      (m_frag_tlast),
        .m_frag_tdata      (m_frag_tdata),
        .m_frag_tstrb      (m_frag_tstrb),
        .m_frag_taddr      (m_frag_taddr),
        .m_frag_txpos      (m_frag_txpos),
        .m_frag_typos      (m_frag_typos),
        .apply             (apply),
        .applied           (applied)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Reference: every pixel of the clamped rectangle in raster order, address = y*XRes + x.
    function automatic void build_expected(input cfg_t c);
        int    x0, x1, y0, y1;
        beat_t b;
        exp_q.delete();
        if (c.sen) begin
            x0 = (c.sx < c.xres) ? c.sx : c.xres;
            x1 = (c.ex < c.xres) ? c.ex : c.xres;
            y0 = (c.sy < c.yres) ? c.sy : c.yres;
            y1 = (c.ey < c.yres) ? c.ey : c.yres;
        end else begin
            x0 = 0;
            x1 = c.xres;
            y0 = 0;
            y1 = c.yres;
        end
        for (int y = y0; y < y1; y++) begin
            for (int x = x0; x < x1; x++) begin
                b.data = c.color;
                b.strb = c.mask;
                b.addr = AW'(y * c.xres + x);
                b.x    = XW'(x);
                b.y    = YW'(y);
                b.last = (x == x1 - 1) && (y == y1 - 1);
                exp_q.push_back(b);
            end
        end
    endfunction

    task automatic randomize_upstream();
        s_frag_tvalid = 1'b1;
        s_frag_tlast  = 1'($urandom);
        s_frag_tdata  = PW'($urandom);
        s_frag_tstrb  = SW'($urandom);
        s_frag_taddr  = $urandom;
        s_frag_txpos  = XW'($urandom);
        s_frag_typos  = YW'($urandom);
    endtask

    // Issues one apply and records what the downstream accepts; judging is left to each test.
    task automatic do_clear(input cfg_t c, input int ready_pct, input bit mid_apply);
        beat_t cur;
        beat_t prev;
        bit    prev_stalled;
        int    cyc;
        obs_q.delete();
        obs_ctrl_errs      = 0;
        obs_stall_changes  = 0;
        obs_timeout        = 0;
        obs_first_valid    = 0;
        obs_pass_ok        = 0;
        obs_applied_stayed = 1;
        prev               = '0;
        prev_stalled       = 0;
        cyc                = 0;
        @(negedge aclk);
        confXResolution   = XW'(c.xres);
        confYResolution   = YW'(c.yres);
        confScissorEnable = c.sen;
        confScissorStartX = XW'(c.sx);
        confScissorStartY = YW'(c.sy);
        confScissorEndX   = XW'(c.ex);
        confScissorEndY   = YW'(c.ey);
        confClearColor    = c.color;
        confClearMask     = c.mask;
        randomize_upstream();
        apply = 1'b1;
        @(negedge aclk);
        apply = 1'b0;
        forever begin
            m_frag_tready = ($urandom_range(99) < ready_pct);
            if (mid_apply && cyc == 3) begin
                apply             = 1'b1;
                confClearColor    = ~c.color;
                confClearMask     = ~c.mask;
                confScissorEnable = 1'b1;
                confScissorStartX = XW'(1);
                confScissorStartY = YW'(1);
                confScissorEndX   = XW'(2);
                confScissorEndY   = YW'(2);
            end else begin
                apply = 1'b0;
            end
            #1;
            if (cyc == 0) obs_first_valid = (m_frag_tvalid === 1'b1) && (applied === 1'b0);
            if (applied !== 1'b0) break;
            if (cyc >= 2000) begin
                obs_timeout = 1;
                break;
            end
            cur = {m_frag_tdata, m_frag_tstrb, m_frag_taddr, m_frag_txpos, m_frag_typos, m_frag_tlast};
            if (m_frag_tvalid !== 1'b1 || s_frag_tready !== 1'b0) obs_ctrl_errs++;
            if (prev_stalled && cur !== prev) obs_stall_changes++;
            if (m_frag_tready) obs_q.push_back(cur);
            prev         = cur;
            prev_stalled = !m_frag_tready;
            cyc++;
            @(negedge aclk);
        end
        apply       = 1'b0;
        obs_pass_ok = (m_frag_tvalid === s_frag_tvalid) && (m_frag_tdata === s_frag_tdata) &&
                      (m_frag_taddr === s_frag_taddr) && (s_frag_tready === m_frag_tready);
        for (int i = 0; i < 3; i++) begin
            if (applied !== 1'b1) obs_applied_stayed = 0;
            @(negedge aclk);
            #1;
        end
    endtask

    task automatic test_reset();
        resetn        = 1'b0;
        apply         = 1'b0;
        m_frag_tready = 1'b1;
        randomize_upstream();
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        #1;
        total++;
        if (applied !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_applied actual=%b required=1", applied);
        end
        total++;
        if ({m_frag_tvalid, m_frag_tdata, m_frag_taddr} !== {s_frag_tvalid, s_frag_tdata, s_frag_taddr}) begin
            bad++;
            $display("[TB] FAIL reset_passthrough actual=%h required=%h",
                     {m_frag_tvalid, m_frag_tdata, m_frag_taddr}, {s_frag_tvalid, s_frag_tdata, s_frag_taddr});
        end
        resetn = 1'b1;
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            randomize_upstream();
            m_frag_tready = 1'($urandom);
            #1;
            total++;
            if ({m_frag_tvalid, m_frag_tlast, m_frag_tdata, m_frag_tstrb, m_frag_taddr, m_frag_txpos, m_frag_typos, s_frag_tready} !==
                {s_frag_tvalid, s_frag_tlast, s_frag_tdata, s_frag_tstrb, s_frag_taddr, s_frag_txpos, s_frag_typos, m_frag_tready}) begin
                bad++;
                $display("[TB] FAIL pass_frag%0d actual=%h required=%h", i,
                         {m_frag_tvalid, m_frag_tlast, m_frag_tdata, m_frag_tstrb, m_frag_taddr, m_frag_txpos, m_frag_typos, s_frag_tready},
                         {s_frag_tvalid, s_frag_tlast, s_frag_tdata, s_frag_tstrb, s_frag_taddr, s_frag_txpos, s_frag_typos, m_frag_tready});
            end
            total++;
            if (applied !== 1'b1) begin
                bad++;
                $display("[TB] FAIL pass_applied%0d actual=%b required=1", i, applied);
            end
        end
    endtask

    task automatic test_full_clear();
        cfg_t c;
        c = '{xres: 4, yres: 3, sen: 0, sx: 0, sy: 0, ex: 0, ey: 0, color: 16'hF81F, mask: 2'b11};
        build_expected(c);
        do_clear(c, 100, 0);
        total++;
        if (obs_q.size() != exp_q.size() || obs_timeout) begin
            bad++;
            $display("[TB] FAIL full_count actual=%0d required=%0d timeout=%0d", obs_q.size(), exp_q.size(), obs_timeout);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("[TB] FAIL full_beat%0d actual=%h required=%h", i, obs_q[i], exp_q[i]);
            end
        end
        total++;
        if (obs_first_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL full_first_valid actual=%b required=1", obs_first_valid);
        end
        total++;
        if (obs_ctrl_errs != 0) begin
            bad++;
            $display("[TB] FAIL full_ctrl actual=%0d required=0", obs_ctrl_errs);
        end
        total++;
        if (obs_pass_ok !== 1'b1 || obs_applied_stayed !== 1'b1) begin
            bad++;
            $display("[TB] FAIL full_return actual=%b%b required=11", obs_pass_ok, obs_applied_stayed);
        end
    endtask

    task automatic test_scissor();
        cfg_t c;
        c = '{xres: 8, yres: 8, sen: 1, sx: 2, sy: 3, ex: 5, ey: 5, color: PW'($urandom), mask: 2'b11};
        build_expected(c);
        do_clear(c, 100, 0);
        total++;
        if (obs_q.size() != 6 || obs_timeout) begin
            bad++;
            $display("[TB] FAIL scissor_count actual=%0d required=6", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("[TB] FAIL scissor_beat%0d actual=%h required=%h", i, obs_q[i], exp_q[i]);
            end
        end
        total++;
        if (obs_ctrl_errs != 0) begin
            bad++;
            $display("[TB] FAIL scissor_ctrl actual=%0d required=0", obs_ctrl_errs);
        end
    endtask

    task automatic test_clamp_empty();
        cfg_t c;
        c = '{xres: 8, yres: 8, sen: 1, sx: 6, sy: 6, ex: 20, ey: 20, color: PW'($urandom), mask: 2'b10};
        build_expected(c);
        do_clear(c, 100, 0);
        total++;
        if (obs_q.size() != 4 || obs_timeout) begin
            bad++;
            $display("[TB] FAIL clamp_count actual=%0d required=4", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("[TB] FAIL clamp_beat%0d actual=%h required=%h", i, obs_q[i], exp_q[i]);
            end
        end
        c = '{xres: 8, yres: 8, sen: 1, sx: 5, sy: 2, ex: 5, ey: 7, color: PW'($urandom), mask: 2'b11};
        do_clear(c, 100, 0);
        total++;
        if (obs_q.size() != 0 || obs_first_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL empty_count actual=%0d required=0", obs_q.size());
        end
        total++;
        if (obs_applied_stayed !== 1'b1 || obs_pass_ok !== 1'b1) begin
            bad++;
            $display("[TB] FAIL empty_idle actual=%b%b required=11", obs_applied_stayed, obs_pass_ok);
        end
    endtask

    task automatic test_backpressure();
        cfg_t c;
        for (int t = 0; t < 4; t++) begin
            if (t == 0) begin
                c = '{xres: 5, yres: 4, sen: 0, sx: 0, sy: 0, ex: 0, ey: 0, color: PW'($urandom), mask: 2'b01};
            end else begin
                c.xres  = int'($urandom_range(10, 2));
                c.yres  = int'($urandom_range(6, 2));
                c.sen   = 1'($urandom);
                c.sx    = int'($urandom_range(c.xres + 2, 0));
                c.ex    = int'($urandom_range(c.xres + 3, 0));
                c.sy    = int'($urandom_range(c.yres + 2, 0));
                c.ey    = int'($urandom_range(c.yres + 3, 0));
                c.color = PW'($urandom);
                c.mask  = 2'b01;
            end
            build_expected(c);
            do_clear(c, 30, t == 0);
            total++;
            if (obs_q.size() != exp_q.size() || obs_timeout) begin
                bad++;
                $display("[TB] FAIL bp%0d_count actual=%0d required=%0d timeout=%0d", t, obs_q.size(), exp_q.size(), obs_timeout);
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                total++;
                if (obs_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("[TB] FAIL bp%0d_beat%0d actual=%h required=%h", t, i, obs_q[i], exp_q[i]);
                end
            end
            total++;
            if (obs_stall_changes != 0 || obs_ctrl_errs != 0) begin
                bad++;
                $display("[TB] FAIL bp%0d_stall actual=%0d/%0d required=0/0", t, obs_stall_changes, obs_ctrl_errs);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int acc = 0;
        int cyc = 0;
        @(negedge aclk);
        confXResolution   = XW'(4);
        confYResolution   = YW'(3);
        confScissorEnable = 1'b0;
        confClearColor    = 16'h1234;
        confClearMask     = 2'b11;
        s_frag_tvalid     = 1'b0;
        m_frag_tready     = 1'b1;
        apply             = 1'b1;
        @(negedge aclk);
        apply = 1'b0;
        while (acc < 4 && cyc < 50) begin
            #1;
            if (m_frag_tvalid === 1'b1) acc++;
            cyc++;
            @(negedge aclk);
        end
        #1;
        total++;
        if (m_frag_tvalid !== 1'b1 || m_frag_taddr !== 32'd4) begin
            bad++;
            $display("[TB] FAIL rst_beat5 actual=%b/%0d required=1/4", m_frag_tvalid, m_frag_taddr);
        end
        resetn = 1'b0;
        @(negedge aclk);
        #1;
        total++;
        if (m_frag_tvalid !== 1'b0 || applied !== 1'b1 || s_frag_tready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rst_abort actual=%b%b%b required=011", m_frag_tvalid, applied, s_frag_tready);
        end
        resetn = 1'b1;
        randomize_upstream();
        @(negedge aclk);
        #1;
        total++;
        if ({m_frag_tvalid, m_frag_tdata, m_frag_taddr} !== {s_frag_tvalid, s_frag_tdata, s_frag_taddr}) begin
            bad++;
            $display("[TB] FAIL rst_passthrough actual=%h required=%h",
                     {m_frag_tvalid, m_frag_tdata, m_frag_taddr}, {s_frag_tvalid, s_frag_tdata, s_frag_taddr});
        end
        s_frag_tvalid = 1'b0;
        @(negedge aclk);
        #1;
        total++;
        if (m_frag_tvalid !== 1'b0 || applied !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rst_no_leftover actual=%b%b required=01", m_frag_tvalid, applied);
        end
    endtask

    initial begin
        resetn            = 1'b0;
        apply             = 1'b0;
        confClearColor    = '0;
        confClearMask     = '0;
        confXResolution   = '0;
        confYResolution   = '0;
        confScissorEnable = 1'b0;
        confScissorStartX = '0;
        confScissorStartY = '0;
        confScissorEndX   = '0;
        confScissorEndY   = '0;
        s_frag_tvalid     = 1'b0;
        s_frag_tlast      = 1'b0;
        s_frag_tdata      = '0;
        s_frag_tstrb      = '0;
        s_frag_taddr      = '0;
        s_frag_txpos      = '0;
        s_frag_typos      = '0;
        m_frag_tready     = 1'b1;

        test_reset();
        test_passthrough();
        test_full_clear();
        test_scissor();
        test_clamp_empty();
        test_backpressure();
        test_reset_mid_clear();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
